// File: rtl/led_stream_writer_if.sv
// Stream-in / panel-write bundle for led_stream_writer.
// master = byte source and panel observer, slave = the writer itself.
interface led_stream_writer_if;
   logic [7:0]  in_data;
   logic        in_sof;
   logic        in_valid;
   logic        in_ready;
   logic        clr_req;
   logic        ctrl_en;
   logic [3:0]  ctrl_wr;
   logic [15:0] ctrl_addr;
   logic [23:0] ctrl_wdat;
   logic        busy;
   logic        frame_done;
   logic        clr_done;
   logic        sof_err;

   modport master (
      output in_data, in_sof, in_valid, clr_req,
      input  in_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat,
      input  busy, frame_done, clr_done, sof_err
   );

   modport slave (
      input  in_data, in_sof, in_valid, clr_req,
      output in_ready, ctrl_en, ctrl_wr, ctrl_addr, ctrl_wdat,
      output busy, frame_done, clr_done, sof_err
   );
endinterface

// File: rtl/led_stream_writer.sv
// RGB888 byte stream to LED panel framebuffer writer, with hardware clear.
// One panel write per assembled pixel; clear writes black to every pixel.
module led_stream_writer #(
   parameter int unsigned CHAINED     = 1,
   parameter int unsigned INPUT_DEPTH = 6
) (
   input  logic               ctrl_clk,
   input  logic               ctrl_rst,
   led_stream_writer_if.slave bus
);

   localparam int unsigned NPIX       = 4096 * CHAINED;
   localparam int unsigned ADDR_WIDTH = 12 + $clog2(CHAINED);
   localparam int unsigned DROP       = 8 - INPUT_DEPTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_PIX = ADDR_WIDTH'(NPIX - 1);

   typedef enum logic [1:0] {
      WAIT_SOF = 2'd0,
      RX       = 2'd1,
      CLEAR    = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            phase_q, phase_d;
   logic [ADDR_WIDTH-1:0] pix_q, pix_d;
   logic [7:0]            r_q, r_d;
   logic [7:0]            g_q, g_d;

   logic                  en_q, en_d;
   logic [3:0]            wr_q, wr_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [23:0]           wdat_q, wdat_d;
   logic                  busy_q, busy_d;
   logic                  frame_done_q, frame_done_d;
   logic                  clr_done_q, clr_done_d;
   logic                  sof_err_q, sof_err_d;

   logic                  in_ready_c;
   logic                  acc_c;
   logic                  pix_last_c;

   function automatic logic [7:0] trunc(input logic [7:0] b);
      return b >> DROP;
   endfunction

   assign in_ready_c = (state_q != CLEAR) && !bus.clr_req;
   assign acc_c      = bus.in_valid && in_ready_c;
   assign pix_last_c = (pix_q == LAST_PIX);

   // State register
   always_ff @(posedge ctrl_clk) begin
      if (ctrl_rst) begin
         state_q <= WAIT_SOF;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and datapath update; pix always holds the next address to write
   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      pix_d   = pix_q;
      r_d     = r_q;
      g_d     = g_q;
      if (bus.clr_req) begin
         // Clear write 0 is issued in the request cycle itself, so pix moves on to 1
         state_d = CLEAR;
         phase_d = 2'd0;
         pix_d   = ADDR_WIDTH'(1);
      end else begin
         case (state_q)
            WAIT_SOF: begin
               if (acc_c && bus.in_sof) begin
                  state_d = RX;
                  r_d     = bus.in_data;
                  phase_d = 2'd1;
                  pix_d   = '0;
               end
            end
            RX: begin
               if (acc_c) begin
                  if (bus.in_sof) begin
                     r_d     = bus.in_data;
                     phase_d = 2'd1;
                     pix_d   = '0;
                  end else begin
                     case (phase_q)
                        2'd0: begin
                           r_d     = bus.in_data;
                           phase_d = 2'd1;
                        end
                        2'd1: begin
                           g_d     = bus.in_data;
                           phase_d = 2'd2;
                        end
                        default: begin
                           phase_d = 2'd0;
                           if (pix_last_c) begin
                              state_d = WAIT_SOF;
                              pix_d   = '0;
                           end else begin
                              pix_d = pix_q + ADDR_WIDTH'(1);
                           end
                        end
                     endcase
                  end
               end
            end
            CLEAR: begin
               if (pix_last_c) begin
                  state_d = WAIT_SOF;
                  pix_d   = '0;
               end else begin
                  pix_d = pix_q + ADDR_WIDTH'(1);
               end
            end
            default: begin
               state_d = WAIT_SOF;
            end
         endcase
      end
   end

   // Next values of the registered panel-side outputs
   always_comb begin
      en_d         = 1'b0;
      addr_d       = '0;
      wdat_d       = '0;
      frame_done_d = 1'b0;
      clr_done_d   = 1'b0;
      sof_err_d    = 1'b0;
      busy_d       = (state_d != WAIT_SOF);
      if (bus.clr_req) begin
         en_d   = 1'b1;
         addr_d = '0;
      end else begin
         case (state_q)
            RX: begin
               if (acc_c) begin
                  if (bus.in_sof) begin
                     sof_err_d = 1'b1;
                  end else if (phase_q == 2'd2) begin
                     en_d         = 1'b1;
                     addr_d       = pix_q;
                     wdat_d       = {trunc(r_q), trunc(g_q), trunc(bus.in_data)};
                     frame_done_d = pix_last_c;
                  end
               end
            end
            CLEAR: begin
               en_d       = 1'b1;
               addr_d     = pix_q;
               clr_done_d = pix_last_c;
            end
            default: begin
            end
         endcase
      end
      wr_d = en_d ? 4'b0111 : 4'b0000;
   end

   // Datapath and output registers
   always_ff @(posedge ctrl_clk) begin
      if (ctrl_rst) begin
         phase_q      <= 2'd0;
         pix_q        <= '0;
         r_q          <= '0;
         g_q          <= '0;
         en_q         <= 1'b0;
         wr_q         <= 4'b0000;
         addr_q       <= '0;
         wdat_q       <= '0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         clr_done_q   <= 1'b0;
         sof_err_q    <= 1'b0;
      end else begin
         phase_q      <= phase_d;
         pix_q        <= pix_d;
         r_q          <= r_d;
         g_q          <= g_d;
         en_q         <= en_d;
         wr_q         <= wr_d;
         addr_q       <= addr_d;
         wdat_q       <= wdat_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         clr_done_q   <= clr_done_d;
         sof_err_q    <= sof_err_d;
      end
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.ctrl_en    = en_q;
   assign bus.ctrl_wr    = wr_q;
   assign bus.ctrl_addr  = 16'(addr_q);
   assign bus.ctrl_wdat  = wdat_q;
   assign bus.busy       = busy_q;
   assign bus.frame_done = frame_done_q;
   assign bus.clr_done   = clr_done_q;
   assign bus.sof_err    = sof_err_q;

endmodule

// File: doc/led_stream_writer.md
# led_stream_writer

Upstream feeder for the LED panel framebuffer, in the `ctrl_clk` domain. It accepts a byte stream of RGB888 pixels in raster order, framed by a start-of-frame flag. It assembles each group of three bytes into one pixel, truncates each channel to 6 bits, and drives the panel's write port (`ctrl_en`/`ctrl_wr`/`ctrl_addr`/`ctrl_wdat`) with one write per pixel. It also provides a hardware framebuffer clear.

## Interface
Parameters:
- `CHAINED`, 1 — panels chained horizontally. Pixel count `NPIX = 4096*CHAINED`. `ADDR_WIDTH = 12 + $clog2(CHAINED)`.
- `INPUT_DEPTH`, 6 — bits per channel delivered to the panel. Must be ≤ 8.

Ports:
- `ctrl_clk` in 1 — the only clock.
- `ctrl_rst` in 1 — reset; synchronous and active-high.
- `in_data` in 8 — stream byte.
- `in_sof` in 1 — qualifies `in_data` as the first (R) byte of a frame.
- `in_valid` in 1 — byte present.
- `in_ready` out 1 — byte accepted when `in_valid && in_ready`.
- `clr_req` in 1 — single-cycle request to write black to all `NPIX` pixels.
- `ctrl_en` out 1 — write strobe to the panel.
- `ctrl_wr` out 4 — channel write enables; always `4'b0111` when `ctrl_en`=1, otherwise 0.
- `ctrl_addr` out 16 — `{y, x}` linear pixel index, zero-extended above `ADDR_WIDTH`.
- `ctrl_wdat` out 24 — `{R, G, B}` bytes; each byte is `{(8-INPUT_DEPTH)'b0, chan[7:8-INPUT_DEPTH]}`.
- `busy` out 1 — high while in `RX` or `CLEAR`.
- `frame_done` out 1 — one-cycle pulse on the cycle the last pixel of a frame is written.
- `clr_done` out 1 — one-cycle pulse on the cycle the last clear write is issued.
- `sof_err` out 1 — one-cycle pulse when a frame is resynchronised by an early `in_sof`.

## Operation
- States: `WAIT_SOF`, `RX`, `CLEAR`. Internal registers:
  - `phase` (0..2): byte position within the current pixel.
  - `pix` (`ADDR_WIDTH` bits): index of the pixel being assembled or cleared.
  - `r_q`, `g_q`: holding registers for the R and G bytes.
- `in_ready = (state != CLEAR) && !clr_req`. This is combinational and has no dependency on `in_valid`.
- `WAIT_SOF`:
  - Accepted bytes with `in_sof`=0 are consumed and discarded.
  - An accepted byte with `in_sof`=1 sets `r_q = in_data`, `phase = 1`, `pix = 0`, and moves to `RX`.
- `RX`, accepted byte with `in_sof`=0:
  - `phase` 0: store the byte in `r_q`.
  - `phase` 1: store the byte in `g_q`.
  - `phase` 2: issue a write of `{r_q, g_q, in_data}` to address `pix`.
  - `phase` advances modulo 3.
- After the `phase` 2 write:
  - If `pix == NPIX-1`: pulse `frame_done`, go to `WAIT_SOF`.
  - Otherwise increment `pix`.
- `RX`, accepted byte with `in_sof`=1:
  - Discard the partial pixel and pulse `sof_err`.
  - Restart as in `WAIT_SOF`: `r_q = byte`, `phase = 1`, `pix = 0`.
  - Pixels already written stay in memory.
- `clr_req` handling:
  - `clr_req`=1 in any state moves the block to `CLEAR` with `pix = 0`, aborting any frame in progress.
  - `frame_done` is not pulsed for an aborted frame.
  - The byte offered in the same cycle is not consumed.
- `CLEAR`:
  - Writes `ctrl_wdat = 0` to `pix` every cycle and increments `pix`.
  - On the write to `NPIX-1`, pulses `clr_done` and goes to `WAIT_SOF`.
  - `clr_req` arriving during `CLEAR` restarts the clear at `pix = 0`.
- `pix` never wraps silently; every path that reaches `NPIX-1` terminates the frame or the clear.

## Timing
- All outputs are registered except `in_ready`.
- Reset values:
  - State `WAIT_SOF`.
  - `ctrl_en`=0, `ctrl_wr`=0, `ctrl_addr`=0, `ctrl_wdat`=0.
  - `busy`=0, `frame_done`=0, `clr_done`=0, `sof_err`=0.
  - `phase`=0, `pix`=0.
- `in_ready` reads 1 in the reset cycle, provided `clr_req`=0.
- Reset mid-frame or mid-clear aborts immediately with no further writes. Memory contents are left as they are.
- Write latency: `ctrl_en` goes high exactly 1 cycle after the handshake of the B byte. `ctrl_addr` and `ctrl_wdat` are valid in that same cycle.
- `frame_done` coincides with the final `ctrl_en`. `ctrl_en` is high for one cycle per pixel.
- Throughput:
  - Stream: one byte per cycle, so one write every 3 cycles at full rate.
  - Clear: one write per cycle. First clear write appears 1 cycle after `clr_req`; last write appears `NPIX` cycles after `clr_req`.
- `sof_err` pulses 1 cycle after the offending handshake.
- `busy` reflects the state registered in the previous cycle.
- Bubbles on `in_valid` are allowed anywhere; `phase` holds across idle cycles.

## Test plan
- Reset, then a full frame of 12288 bytes with `in_sof` on byte 0, `in_valid` held high:
  - Exactly 4096 writes with addresses 0..4095 in order.
  - Pixel 5 bytes `0xFF,0x80,0x03` produce `ctrl_wdat = 0x3F2000`.
  - `ctrl_wr` is `4'b0111` on every write.
  - `frame_done` fires once, with the write to 4095.
- Leading garbage `0x11,0x22` with `in_sof`=0, then an SOF frame: no writes before the SOF byte; the first write is at address 0.
- Mid-frame resync: after 10 pixels plus 2 bytes, send SOF `0xA4,0x00,0x00`:
  - `sof_err` pulses once.
  - The next write is addr 0, data `0x290000`.
- `clr_req` during pixel 100 with `in_valid`=1:
  - `in_ready`=0 in that cycle.
  - 4096 consecutive zero writes at addresses 0..4095.
  - `clr_done` fires on the last write.
  - No `frame_done`.
- Random `in_valid` gaps (~30%) over a full frame: the written data matches the reference model, the address sequence is unchanged, and there are no duplicate writes.
- `ctrl_rst` asserted during `CLEAR` at pix 2000: `ctrl_en`=0 in the following cycle; state is `WAIT_SOF`; `busy`=0.
